// File: rtl/cci_mpf_csrs_pkg.sv
// Shared MPF CSR types, register byte offsets and read-response record.
package cci_mpf_csrs_pkg;

  localparam int CCI_CLADDR_WIDTH = 42;
  typedef logic [CCI_CLADDR_WIDTH-1:0] t_cci_claddr;

  typedef struct packed {
    logic inval_translation_cache;
    logic enabled;
  } t_cci_mpf_vtp_csr_mode;

  typedef logic [63:0] t_cci_mpf_csr_cnt;
  typedef logic [63:0] t_cci_mmio_data;
  typedef logic [8:0]  t_cci_mmio_tid;

  localparam int MODE_W   = $bits(t_cci_mpf_vtp_csr_mode);
  localparam int CLADDR_W = $bits(t_cci_claddr);

  localparam logic [5:0] CCI_MPF_CSR_VTP_MODE                 = 6'h00;
  localparam logic [5:0] CCI_MPF_CSR_VTP_PAGE_TABLE_BASE      = 6'h08;
  localparam logic [5:0] CCI_MPF_CSR_VTP_OUT_NUM_HITS         = 6'h10;
  localparam logic [5:0] CCI_MPF_CSR_VTP_OUT_NUM_MISSES       = 6'h18;
  localparam logic [5:0] CCI_MPF_CSR_WRO_OUT_NUM_WRITES       = 6'h20;
  localparam logic [5:0] CCI_MPF_CSR_WRO_OUT_NUM_READS        = 6'h28;
  localparam logic [5:0] CCI_MPF_CSR_WRO_OUT_NUM_WR_CONFLICTS = 6'h30;
  localparam logic [5:0] CCI_MPF_CSR_WRO_OUT_NUM_RD_CONFLICTS = 6'h38;

  typedef struct packed {
    t_cci_mmio_data data;
    t_cci_mmio_tid  tid;
  } t_cci_mpf_csr_rsp;

  // An odd DWORD read returns the upper half right-justified.
  function automatic logic [63:0] csr_dword_sel(input logic [63:0] r, input logic hi);
    return hi ? {32'b0, r[63:32]} : r;
  endfunction

endpackage

// File: rtl/cci_mpf_csrs.sv
// Control/statistics bundle between the CSR manager and the VTP/WRO shims.
interface cci_mpf_csrs;
  import cci_mpf_csrs_pkg::*;

  t_cci_mpf_vtp_csr_mode vtp_in_mode;
  t_cci_claddr           vtp_in_page_table_base;
  logic                  vtp_in_page_table_base_valid;

  t_cci_mpf_csr_cnt vtp_out_num_hits;
  t_cci_mpf_csr_cnt vtp_out_num_misses;
  t_cci_mpf_csr_cnt wro_out_num_writes;
  t_cci_mpf_csr_cnt wro_out_num_reads;
  t_cci_mpf_csr_cnt wro_out_num_write_conflicts;
  t_cci_mpf_csr_cnt wro_out_num_read_conflicts;

  modport csr (
    output vtp_in_mode, vtp_in_page_table_base, vtp_in_page_table_base_valid,
    input  vtp_out_num_hits, vtp_out_num_misses,
           wro_out_num_writes, wro_out_num_reads,
           wro_out_num_write_conflicts, wro_out_num_read_conflicts
  );

  modport shim (
    input  vtp_in_mode, vtp_in_page_table_base, vtp_in_page_table_base_valid,
    output vtp_out_num_hits, vtp_out_num_misses,
           wro_out_num_writes, wro_out_num_reads,
           wro_out_num_write_conflicts, wro_out_num_read_conflicts
  );

endinterface

// File: rtl/cci_mpf_csr_rsp_fifo.sv
// Show-ahead response FIFO: head visible the cycle after enqueue; caller must not
// enqueue when full unless dequeuing in the same cycle.
module cci_mpf_csr_rsp_fifo
  import cci_mpf_csrs_pkg::*;
#(
  parameter int DEPTH = 8
)
(
  input  logic             clk,
  input  logic             reset,
  input  logic             enq_en,
  input  t_cci_mpf_csr_rsp enq_data,
  input  logic             deq_en,
  output t_cci_mpf_csr_rsp first,
  output logic             notEmpty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = 1;
  localparam logic [AW:0]   CNT_ONE  = 1;
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  t_cci_mpf_csr_rsp mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    if (enq_en) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (deq_en) rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({enq_en, deq_en})
      2'b10:   cnt_d = cnt_q + CNT_ONE;
      2'b01:   cnt_d = cnt_q - CNT_ONE;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset: only slots behind a valid count are ever observed.
  always_ff @(posedge clk) begin
    if (enq_en) mem_q[wr_ptr_q] <= enq_data;
  end

  assign first    = mem_q[rd_ptr_q];
  assign notEmpty = (cnt_q != '0);
  assign full     = (cnt_q == CNT_FULL);

endmodule

// File: rtl/cci_mpf_csr_mgr.sv
// MPF CSR manager: MMIO writes -> VTP control regs (1 cycle); MMIO reads -> stats
// responses 2 cycles later via a FIFO drained by rsp_ready; reads on a full FIFO drop and flag.
module cci_mpf_csr_mgr
  import cci_mpf_csrs_pkg::*;
#(
  parameter logic [15:0] CSR_BASE       = 16'h0100,
  parameter int          RSP_FIFO_DEPTH = 8
)
(
  input  logic        clk,
  input  logic        reset,
  input  logic        mmio_wr_valid,
  input  logic [15:0] mmio_wr_addr,
  input  logic        mmio_wr_is_64,
  input  logic [63:0] mmio_wr_data,
  input  logic        mmio_rd_valid,
  input  logic [15:0] mmio_rd_addr,
  input  logic [8:0]  mmio_rd_tid,
  output logic        rsp_valid,
  output logic [63:0] rsp_data,
  output logic [8:0]  rsp_tid,
  input  logic        rsp_ready,
  output logic        err_rsp_overflow,
  cci_mpf_csrs.csr    csrs
);

  logic [15:0] wr_off, rd_off;
  logic        wr_hit, rd_hit, wr_hi, rd_hi;
  logic [5:0]  wr_reg, rd_reg;

  assign wr_off = mmio_wr_addr - CSR_BASE;
  assign rd_off = mmio_rd_addr - CSR_BASE;
  assign wr_hit = (wr_off[15:4] == '0);
  assign rd_hit = (rd_off[15:4] == '0);
  assign wr_hi  = wr_off[0];
  assign rd_hi  = rd_off[0];
  assign wr_reg = {wr_off[3:1], 3'b000};
  assign rd_reg = {rd_off[3:1], 3'b000};

  t_cci_mpf_vtp_csr_mode mode_q, mode_d;
  t_cci_claddr           base_q, base_d;
  logic [31:0]           shadow_q, shadow_d;
  logic                  base_vld_q, base_vld_d;
  logic [63:0]           base_cat;
  logic                  unused_wr_bits;

  assign base_cat       = {mmio_wr_data[31:0], shadow_q};
  assign unused_wr_bits = ^mmio_wr_data[63:CLADDR_W];

  always_comb begin
    mode_d     = mode_q;
    base_d     = base_q;
    shadow_d   = shadow_q;
    base_vld_d = base_vld_q;
    if (mmio_wr_valid && wr_hit) begin
      case (wr_reg)
        CCI_MPF_CSR_VTP_MODE: begin
          if (!wr_hi) mode_d = mmio_wr_data[MODE_W-1:0];
        end
        CCI_MPF_CSR_VTP_PAGE_TABLE_BASE: begin
          if (mmio_wr_is_64) begin
            if (!wr_hi) begin
              base_d     = mmio_wr_data[CLADDR_W-1:0];
              base_vld_d = 1'b1;
            end
          end else if (!wr_hi) begin
            shadow_d = mmio_wr_data[31:0];
          end else begin
            base_d     = base_cat[CLADDR_W-1:0];
            base_vld_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  logic [63:0] rd_reg_val;

  always_comb begin
    rd_reg_val = '0;
    case (rd_reg)
      CCI_MPF_CSR_VTP_MODE:                 rd_reg_val = 64'(mode_q);
      CCI_MPF_CSR_VTP_PAGE_TABLE_BASE:      rd_reg_val = 64'(base_q);
      CCI_MPF_CSR_VTP_OUT_NUM_HITS:         rd_reg_val = csrs.vtp_out_num_hits;
      CCI_MPF_CSR_VTP_OUT_NUM_MISSES:       rd_reg_val = csrs.vtp_out_num_misses;
      CCI_MPF_CSR_WRO_OUT_NUM_WRITES:       rd_reg_val = csrs.wro_out_num_writes;
      CCI_MPF_CSR_WRO_OUT_NUM_READS:        rd_reg_val = csrs.wro_out_num_reads;
      CCI_MPF_CSR_WRO_OUT_NUM_WR_CONFLICTS: rd_reg_val = csrs.wro_out_num_write_conflicts;
      CCI_MPF_CSR_WRO_OUT_NUM_RD_CONFLICTS: rd_reg_val = csrs.wro_out_num_read_conflicts;
      default:                              rd_reg_val = '0;
    endcase
  end

  t_cci_mpf_csr_rsp stg_q, stg_d, fifo_first;
  logic             stg_vld_q, stg_vld_d;
  logic             err_q, err_d;
  logic             fifo_enq, fifo_deq, fifo_full, fifo_not_empty;

  assign fifo_deq = fifo_not_empty && rsp_ready;
  // A dequeue in the same cycle frees the slot, so a full FIFO can still accept.
  assign fifo_enq = stg_vld_q && (!fifo_full || fifo_deq);

  always_comb begin
    stg_vld_d  = mmio_rd_valid && rd_hit;
    stg_d.data = csr_dword_sel(rd_reg_val, rd_hi);
    stg_d.tid  = mmio_rd_tid;
    err_d      = err_q || (stg_vld_q && !fifo_enq);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_q     <= '0;
      base_q     <= '0;
      shadow_q   <= '0;
      base_vld_q <= 1'b0;
      stg_vld_q  <= 1'b0;
      stg_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      mode_q     <= mode_d;
      base_q     <= base_d;
      shadow_q   <= shadow_d;
      base_vld_q <= base_vld_d;
      stg_vld_q  <= stg_vld_d;
      stg_q      <= stg_d;
      err_q      <= err_d;
    end
  end

  cci_mpf_csr_rsp_fifo #(.DEPTH(RSP_FIFO_DEPTH)) u_rsp_fifo (
    .clk      (clk),
    .reset    (reset),
    .enq_en   (fifo_enq),
    .enq_data (stg_q),
    .deq_en   (fifo_deq),
    .first    (fifo_first),
    .notEmpty (fifo_not_empty),
    .full     (fifo_full)
  );

  assign rsp_valid        = fifo_not_empty;
  assign rsp_data         = fifo_first.data;
  assign rsp_tid          = fifo_first.tid;
  assign err_rsp_overflow = err_q;

  assign csrs.vtp_in_mode                  = mode_q;
  assign csrs.vtp_in_page_table_base       = base_q;
  assign csrs.vtp_in_page_table_base_valid = base_vld_q;

endmodule

// File: tb/tb_cci_mpf_csr_mgr.sv
// Scoreboard bench for cci_mpf_csr_mgr against a register-map reference model.
module tb_cci_mpf_csr_mgr;
  import cci_mpf_csrs_pkg::*;

  localparam logic [15:0] BASE  = 16'h0100;
  localparam int          DEPTH = 8;
  localparam logic [63:0] CLMASK   = (64'd1 << $bits(t_cci_claddr)) - 64'd1;
  localparam logic [63:0] MODEMASK = (64'd1 << $bits(t_cci_mpf_vtp_csr_mode)) - 64'd1;

  logic        clk, reset;
  logic        mmio_wr_valid, mmio_wr_is_64, mmio_rd_valid, rsp_valid, rsp_ready, err_rsp_overflow;
  logic [15:0] mmio_wr_addr, mmio_rd_addr;
  logic [63:0] mmio_wr_data, rsp_data;
  logic [8:0]  mmio_rd_tid, rsp_tid;

  cci_mpf_csrs csrs_if ();

  cci_mpf_csr_mgr #(.CSR_BASE(BASE), .RSP_FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .mmio_wr_valid(mmio_wr_valid), .mmio_wr_addr(mmio_wr_addr),
    .mmio_wr_is_64(mmio_wr_is_64), .mmio_wr_data(mmio_wr_data),
    .mmio_rd_valid(mmio_rd_valid), .mmio_rd_addr(mmio_rd_addr), .mmio_rd_tid(mmio_rd_tid),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_tid(rsp_tid), .rsp_ready(rsp_ready),
    .err_rsp_overflow(err_rsp_overflow), .csrs(csrs_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [63:0] d; logic [8:0] t; } exp_t;
  exp_t sb[$];

  logic [63:0] m_mode, m_base;
  logic [31:0] m_shadow;
  logic        m_base_vld, m_ovf;
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  function automatic logic [63:0] model_reg(input int idx);
    case (idx)
      0: return m_mode;
      1: return m_base;
      2: return csrs_if.vtp_out_num_hits;
      3: return csrs_if.vtp_out_num_misses;
      4: return csrs_if.wro_out_num_writes;
      5: return csrs_if.wro_out_num_reads;
      6: return csrs_if.wro_out_num_write_conflicts;
      7: return csrs_if.wro_out_num_read_conflicts;
      default: return 64'd0;
    endcase
  endfunction

  // Drive one cycle of stimulus; predicted read data uses pre-write register state.
  task automatic step(input bit wv, input logic [15:0] wa, input bit w64, input logic [63:0] wd,
                      input bit rv, input logic [15:0] ra, input logic [8:0] tid, input bit rdy);
    int woff, roff;
    logic [63:0] r;
    exp_t e;
    mmio_wr_valid = wv; mmio_wr_addr = wa; mmio_wr_is_64 = w64; mmio_wr_data = wd;
    mmio_rd_valid = rv; mmio_rd_addr = ra; mmio_rd_tid = tid; rsp_ready = rdy;
    roff = int'(ra) - int'(BASE);
    if (rv && roff >= 0 && roff < 16) begin
      r = model_reg(roff / 2);
      if (roff % 2 == 1) r = r >> 32;
      e.d = r; e.t = tid;
      if (sb.size() < DEPTH) sb.push_back(e);
      else m_ovf = 1'b1;
    end
    @(posedge clk); #1;
    woff = int'(wa) - int'(BASE);
    if (wv && woff >= 0 && woff < 16) begin
      if (woff / 2 == 0 && woff % 2 == 0) m_mode = wd & MODEMASK;
      if (woff / 2 == 1) begin
        if (w64) begin
          if (woff % 2 == 0) begin m_base = wd & CLMASK; m_base_vld = 1'b1; end
        end else if (woff % 2 == 0) begin
          m_shadow = wd[31:0];
        end else begin
          m_base = {wd[31:0], m_shadow} & CLMASK; m_base_vld = 1'b1;
        end
      end
    end
    mmio_wr_valid = 1'b0; mmio_rd_valid = 1'b0;
    check("if_mode", 64'(csrs_if.vtp_in_mode), m_mode);
    check("if_base", 64'(csrs_if.vtp_in_page_table_base), m_base);
    check("if_base_vld", 64'(csrs_if.vtp_in_page_table_base_valid), 64'(m_base_vld));
  endtask

  task automatic idle(input bit rdy);
    step(1'b0, 16'h0, 1'b0, 64'h0, 1'b0, 16'h0, 9'h0, rdy);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin idle(1'b1); n++; end
    check("drain_pending", 64'(sb.size()), 64'd0);
  endtask

  // Monitor: pops the scoreboard on every accepted response and checks hold-while-stalled.
  initial begin
    bit stalled = 1'b0;
    logic [63:0] sd;
    logic [8:0]  st;
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset) stalled = 1'b0;
      else begin
        if (stalled) begin
          check("hold_vld", 64'(rsp_valid), 64'd1);
          check("hold_data", rsp_data, sd);
          check("hold_tid", 64'(rsp_tid), 64'(st));
        end
        if (rsp_valid && rsp_ready) begin
          if (sb.size() == 0) check("unexpected_rsp_vld", 64'(rsp_valid), 64'd0);
          else begin
            e = sb.pop_front();
            check("rsp_data", rsp_data, e.d);
            check("rsp_tid", 64'(rsp_tid), 64'(e.t));
          end
        end
        stalled = rsp_valid && !rsp_ready;
        sd = rsp_data; st = rsp_tid;
      end
    end
  end

  initial begin
    reset = 1'b0;
    mmio_wr_valid = 1'b0; mmio_wr_addr = '0; mmio_wr_is_64 = 1'b0; mmio_wr_data = '0;
    mmio_rd_valid = 1'b0; mmio_rd_addr = '0; mmio_rd_tid = '0; rsp_ready = 1'b1;
    csrs_if.vtp_out_num_hits = '0; csrs_if.vtp_out_num_misses = '0;
    csrs_if.wro_out_num_writes = '0; csrs_if.wro_out_num_reads = '0;
    csrs_if.wro_out_num_write_conflicts = '0; csrs_if.wro_out_num_read_conflicts = '0;
    m_mode = '0; m_base = '0; m_shadow = '0; m_base_vld = 1'b0; m_ovf = 1'b0;
    #1 reset = 1'b1;
    #2;
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_err", 64'(err_rsp_overflow), 64'd0);
    check("rst_base_vld", 64'(csrs_if.vtp_in_page_table_base_valid), 64'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;

    // Reset state, then 64-bit and split page-table-base writes
    step(1'b0, 16'h0, 1'b0, 64'h0, 1'b1, BASE + 16'd2, 9'h010, 1'b1);
    check("base_vld_after_rst", 64'(csrs_if.vtp_in_page_table_base_valid), 64'd0);
    step(1'b1, BASE + 16'd2, 1'b1, 64'h1_2345_6789, 1'b0, 16'h0, 9'h0, 1'b1);
    check("base64", 64'(csrs_if.vtp_in_page_table_base), 64'h1_2345_6789);
    check("base64_vld", 64'(csrs_if.vtp_in_page_table_base_valid), 64'd1);
    step(1'b0, 16'h0, 1'b0, 64'h0, 1'b1, BASE + 16'd2, 9'h011, 1'b1);
    step(1'b1, BASE + 16'd2, 1'b0, 64'hAAAA_0000, 1'b0, 16'h0, 9'h0, 1'b1);
    check("base_split_lo", 64'(csrs_if.vtp_in_page_table_base), 64'h1_2345_6789);
    step(1'b1, BASE + 16'd3, 1'b0, 64'h5, 1'b0, 16'h0, 9'h0, 1'b1);
    check("base_split_hi", 64'(csrs_if.vtp_in_page_table_base), 64'h5_AAAA_0000);

    // Counter reads, odd DWORD, and a miss just past the window
    csrs_if.vtp_out_num_hits = 64'd7;
    csrs_if.vtp_out_num_misses = 64'hF_FFFF_FFF1;
    step(1'b0, 16'h0, 1'b0, 64'h0, 1'b1, BASE + 16'd4, 9'd1, 1'b1);
    step(1'b0, 16'h0, 1'b0, 64'h0, 1'b1, BASE + 16'd6, 9'd2, 1'b1);
    step(1'b0, 16'h0, 1'b0, 64'h0, 1'b1, BASE + 16'd7, 9'd3, 1'b1);
    step(1'b0, 16'h0, 1'b0, 64'h0, 1'b1, BASE + 16'd16, 9'd4, 1'b1);

    // Same-cycle write and read of mode
    step(1'b1, BASE, 1'b0, 64'h3, 1'b1, BASE, 9'd5, 1'b1);
    step(1'b0, 16'h0, 1'b0, 64'h0, 1'b1, BASE, 9'd6, 1'b1);
    drain();

    for (int i = 0; i < 400; i++) begin
      logic [15:0] wa, ra;
      bit rv;
      if ($urandom_range(0, 3) == 0) begin
        csrs_if.vtp_out_num_hits = rnd64(); csrs_if.vtp_out_num_misses = rnd64();
        csrs_if.wro_out_num_writes = rnd64(); csrs_if.wro_out_num_reads = rnd64();
        csrs_if.wro_out_num_write_conflicts = rnd64(); csrs_if.wro_out_num_read_conflicts = rnd64();
      end
      wa = BASE - 16'd2 + 16'($urandom_range(0, 21));
      ra = BASE - 16'd2 + 16'($urandom_range(0, 21));
      rv = ($urandom_range(0, 2) != 0) && (sb.size() < DEPTH);
      step(1'($urandom_range(0, 1)), wa, 1'($urandom_range(0, 1)), rnd64(),
           rv, ra, 9'($urandom), $urandom_range(0, 3) != 0);
    end
    drain();

    // Overflow: nine reads against a stalled arbiter
    check("err_before_ovf", 64'(err_rsp_overflow), 64'd0);
    for (int i = 0; i < 9; i++)
      step(1'b0, 16'h0, 1'b0, 64'h0, 1'b1, BASE + 16'(i % 16), 9'(9'h100 + i), 1'b0);
    repeat (4) idle(1'b0);
    check("err_after_ovf", 64'(err_rsp_overflow), 64'(m_ovf));
    drain();
    check("err_sticky", 64'(err_rsp_overflow), 64'd1);

    // Asynchronous reset with responses queued and in flight
    for (int i = 0; i < 3; i++)
      step(1'b0, 16'h0, 1'b0, 64'h0, 1'b1, BASE + 16'd4, 9'(9'h1F0 + i), 1'b0);
    #2 reset = 1'b1;
    #1;
    sb.delete();
    m_mode = '0; m_base = '0; m_shadow = '0; m_base_vld = 1'b0; m_ovf = 1'b0;
    check("arst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("arst_err", 64'(err_rsp_overflow), 64'd0);
    check("arst_base", 64'(csrs_if.vtp_in_page_table_base), 64'd0);
    check("arst_base_vld", 64'(csrs_if.vtp_in_page_table_base_valid), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    step(1'b0, 16'h0, 1'b0, 64'h0, 1'b1, BASE + 16'd2, 9'h0AA, 1'b1);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cci_mpf_csr_mgr.md
# cci_mpf_csr_mgr

Central MPF CSR manager. It sits between the host MMIO channel and the MPF shims and drives the manager side of the `cci_mpf_csrs` interface. Host MMIO writes update the VTP control registers. Host MMIO reads return VTP and WRO statistics through a small response FIFO, because the downstream MMIO-response arbiter applies backpressure and the MMIO read channel has none.

## Interface
Parameters:
- `CSR_BASE`, default 16'h0100: DWORD address of CSR offset 0. Must be 16-DWORD aligned.
- `RSP_FIFO_DEPTH`, default 8: read-response FIFO entries, power of 2, minimum 2.

Ports:
- `clk`  in  1: the only clock.
- `reset`  in  1: asynchronous, active-high.
- `mmio_wr_valid`  in  1: MMIO write strobe.
- `mmio_wr_addr`  in  16: DWORD address.
- `mmio_wr_is_64`  in  1: 1 = 64-bit write, 0 = 32-bit write.
- `mmio_wr_data`  in  64: write data; 32-bit writes use [31:0].
- `mmio_rd_valid`  in  1: MMIO read strobe; cannot be stalled.
- `mmio_rd_addr`  in  16: DWORD address.
- `mmio_rd_tid`  in  9: transaction ID, echoed in the response.
- `rsp_valid`  out  1: response available.
- `rsp_data`  out  64: response data.
- `rsp_tid`  out  9: echoed transaction ID.
- `rsp_ready`  in  1: arbiter accepts the response this cycle.
- `err_rsp_overflow`  out  1: sticky; set when a read was dropped on a full FIFO.
- `csrs`  interface  -: `cci_mpf_csrs.csr` modport.

## Operation
- Hit rule: an access hits when `addr − CSR_BASE` is in [0,16). Register index = offset[3:1]; offset[0] selects the high DWORD.
- Register map (byte offsets):
  - 0x00: VTP mode. RW, low `$bits(t_cci_mpf_vtp_csr_mode)` bits.
  - 0x08: page table base. RW, line address in low `$bits(t_cci_claddr)` bits.
  - 0x10: `vtp_out_num_hits`. RO.
  - 0x18: `vtp_out_num_misses`. RO.
  - 0x20: `wro_out_num_writes`. RO.
  - 0x28: `wro_out_num_reads`. RO.
  - 0x30: `wro_out_num_write_conflicts`. RO.
  - 0x38: `wro_out_num_read_conflicts`. RO.
- Writes:
  - 64-bit write to an even DWORD updates the register whole.
  - 32-bit write to the low DWORD of the page table base latches into a shadow and leaves outputs unchanged.
  - 32-bit write to the high DWORD commits {data[31:0], shadow} to the base.
  - 32-bit writes to the mode register update only from the low DWORD.
  - Writes to RO offsets, misses, and 64-bit writes to odd DWORDs are ignored.
- `vtp_in_page_table_base_valid` goes 1 on any committed base write and stays 1 until reset.
- Reads:
  - Hit: returns the 64-bit register (mode/base zero-extended); an odd DWORD returns the high half in [31:0].
  - Miss: no response. Other MMIO responders own those addresses.
- FIFO full on a hit read: the read is dropped, no response is generated, and `err_rsp_overflow` is set.
- Reset values:
  - `vtp_in_mode`, `vtp_in_page_table_base`, shadow: 0.
  - Base valid: 0.
  - `rsp_valid`: 0.
  - `err_rsp_overflow`: 0.
  - FIFO: empty.

## Timing
- Write at edge N: the interface output changes after edge N+1 (registered).
- Read at cycle N: data is sampled from values valid in cycle N, so a same-cycle write to the same register returns the old value. A stage register captures it at N+1 and it enqueues at N+2.
- Response: with the FIFO empty, `rsp_valid` is high in cycle N+2. The FIFO is show-ahead: `rsp_data`/`rsp_tid` are valid whenever `rsp_valid` is high.
- Handshake: dequeue when `rsp_valid && rsp_ready`. Data holds stable while `rsp_valid && !rsp_ready`.
- Full check uses the registered count minus a same-cycle dequeue, so enqueue and dequeue at full in the same cycle succeeds.
- Throughput: one read accepted per cycle, one response per cycle.
- Asynchronous reset mid-operation: in-flight reads and queued responses are discarded, and all outputs take reset values immediately.

## Structure
- Shared in `cci_mpf_csrs_pkg`:
  - `CCI_MPF_CSR_*` byte-offset constants.
  - `t_cci_mpf_csr_rsp` struct holding data and tid.
- Sub-module `cci_mpf_csr_rsp_fifo`: parameterised show-ahead FIFO of `t_cci_mpf_csr_rsp` with async reset, `full`, and `notEmpty`.
- The remainder (decode, registers, read mux, stage register) lives flat in `cci_mpf_csr_mgr`.

## Test plan
- **Reset state:** after reset, reading offset 0x08 returns 0 and base valid = 0.
- **Page table base, 64-bit:** 64-bit write 0x123456789 to 0x08 → base = 0x123456789 and valid = 1 one cycle later; a read returns 0x123456789 at N+2.
- **Page table base, split:** 32-bit 0xAAAA0000 to DWORD 2, then 0x5 to DWORD 3 → base unchanged after the first write, 0x5_AAAA0000 after the second.
- **Counter reads:** drive hits=7, misses=0xFFFF_FFFF_1 and read 0x10, 0x18, then DWORD 7 with tids 1,2,3 → responses 7, 0xFFFF_FFFF_1, 0xF in order with tids 1,2,3. A miss at `CSR_BASE`+16 produces nothing.
- **Same-cycle read/write:** write mode=3 and read 0x00 in the same cycle → read returns 0, the next read returns 3.
- **Overflow:** hold `rsp_ready`=0 and issue 9 reads with `RSP_FIFO_DEPTH`=8 → 8 responses queued, the 9th dropped, `err_rsp_overflow`=1. Release ready → 8 responses in tid order, and the flag stays set until reset.
